// File: rtl/post_hash_pkg.sv
// rtl/post_hash_pkg.sv - width defaults, beat-type encoding and unpacker FSM states for the post-hash pipeline
`ifndef HASH_ISSUE_WIDTH
`define HASH_ISSUE_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef META_MATCH_LEN_WIDTH
`define META_MATCH_LEN_WIDTH 6
`endif

package post_hash_pkg;

    typedef enum logic {
        UNPACK_IDLE  = 1'b0,
        UNPACK_DRAIN = 1'b1
    } unpack_state_e;

    typedef enum logic {
        BEAT_DELIM = 1'b0,
        BEAT_HIT   = 1'b1
    } beat_type_e;

endpackage

// File: rtl/lowest_one_encoder.sv
// rtl/lowest_one_encoder.sv - lowest set bit of a mask as index, one-hot and found flag
module lowest_one_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot,
    output logic             found
);

    assign onehot = mask & (~mask + WIDTH'(1));
    assign found  = |mask;

    always_comb begin
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) index = IDX_W'(i);
        end
    end

endmodule

// File: rtl/hash_window_unpacker.sv
// rtl/hash_window_unpacker.sv - serialises hash windows into one beat per hit lane
// Optional HASH_UNPACK_LEN_FILTER_EN drops short, non-extendable lanes at load time.
module hash_window_unpacker
    import post_hash_pkg::*;
#(
    parameter int HASH_ISSUE_WIDTH     = `HASH_ISSUE_WIDTH,
    parameter int ADDR_WIDTH           = `ADDR_WIDTH,
    parameter int META_MATCH_LEN_WIDTH = `META_MATCH_LEN_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [ADDR_WIDTH-1:0]                        in_head_addr,
    input  logic [HASH_ISSUE_WIDTH-1:0]                  in_history_valid,
    input  logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]       in_history_addr,
    input  logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] in_meta_match_len,
    input  logic [HASH_ISSUE_WIDTH-1:0]                  in_meta_match_can_ext,
    input  logic [HASH_ISSUE_WIDTH*8-1:0]                in_data,
    input  logic                                         in_delim,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_hit,
    output logic [ADDR_WIDTH-1:0]                        out_addr,
    output logic [ADDR_WIDTH-1:0]                        out_history_addr,
    output logic [META_MATCH_LEN_WIDTH-1:0]              out_meta_match_len,
    output logic                                         out_meta_match_can_ext,
    output logic [7:0]                                   out_data,
    output logic                                         out_last,
    output logic                                         out_delim
`ifdef HASH_UNPACK_LEN_FILTER_EN
    ,
    input  logic [META_MATCH_LEN_WIDTH-1:0]              cfg_min_match_len
`endif
);

    localparam int IDX_W = $clog2(HASH_ISSUE_WIDTH);

    unpack_state_e                                  state;
    logic [HASH_ISSUE_WIDTH-1:0]                    pend;
    logic [ADDR_WIDTH-1:0]                          head_q;
    logic [HASH_ISSUE_WIDTH*ADDR_WIDTH-1:0]         hist_q;
    logic [HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH-1:0] len_q;
    logic [HASH_ISSUE_WIDTH-1:0]                    ext_q;
    logic [HASH_ISSUE_WIDTH*8-1:0]                  data_q;
    logic                                           delim_q;

    logic [IDX_W-1:0]            lane;
    logic [HASH_ISSUE_WIDTH-1:0] lane_onehot;
    logic                        lane_found;
    logic [HASH_ISSUE_WIDTH-1:0] load_mask;
    logic                        drain, beat_last, in_fire, out_fire;

    lowest_one_encoder #(
        .WIDTH (HASH_ISSUE_WIDTH),
        .IDX_W (IDX_W)
    ) u_lowest_one (
        .mask   (pend),
        .index  (lane),
        .onehot (lane_onehot),
        .found  (lane_found)
    );

    assign drain     = (state == UNPACK_DRAIN);
    // An empty pending mask in DRAIN is the lone delim marker, so it is also last.
    assign beat_last = ((pend & ~lane_onehot) == '0);
    assign out_valid = drain;
    assign out_last  = drain & beat_last;
    assign out_delim = drain & beat_last & delim_q;
    assign in_ready  = !drain | (out_ready & beat_last);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        load_mask = in_history_valid;
`ifdef HASH_UNPACK_LEN_FILTER_EN
        for (int i = 0; i < HASH_ISSUE_WIDTH; i++) begin
            if (!in_meta_match_can_ext[i] &&
                (in_meta_match_len[i*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH] < cfg_min_match_len))
                load_mask[i] = 1'b0;
        end
`endif
    end

    always_comb begin
        out_hit                = BEAT_DELIM;
        out_addr               = '0;
        out_history_addr       = '0;
        out_meta_match_len     = '0;
        out_meta_match_can_ext = 1'b0;
        out_data               = '0;
        if (drain) begin
            out_addr = head_q + ADDR_WIDTH'(lane);
            if (lane_found) begin
                out_hit                = BEAT_HIT;
                out_history_addr       = hist_q[lane*ADDR_WIDTH +: ADDR_WIDTH];
                out_meta_match_len     = len_q[lane*META_MATCH_LEN_WIDTH +: META_MATCH_LEN_WIDTH];
                out_meta_match_can_ext = ext_q[lane];
                out_data               = data_q[lane*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= UNPACK_IDLE;
            pend    <= '0;
            head_q  <= '0;
            hist_q  <= '0;
            len_q   <= '0;
            ext_q   <= '0;
            data_q  <= '0;
            delim_q <= 1'b0;
        end else if (in_fire) begin
            state   <= ((|load_mask) || in_delim) ? UNPACK_DRAIN : UNPACK_IDLE;
            pend    <= load_mask;
            head_q  <= in_head_addr;
            hist_q  <= in_history_addr;
            len_q   <= in_meta_match_len;
            ext_q   <= in_meta_match_can_ext;
            data_q  <= in_data;
            delim_q <= in_delim;
        end else if (out_fire) begin
            if (beat_last) begin
                state <= UNPACK_IDLE;
                pend  <= '0;
            end else begin
                pend  <= pend & ~lane_onehot;
            end
        end
    end

endmodule

// File: tb/tb_hash_window_unpacker.sv
// tb/tb_hash_window_unpacker.sv - randomized and directed bench for hash_window_unpacker
module tb_hash_window_unpacker;

    localparam int HW = 8;
    localparam int AW = 16;
    localparam int LW = 6;
    localparam int BW = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     in_head_addr;
    logic [HW-1:0]     in_history_valid;
    logic [HW*AW-1:0]  in_history_addr;
    logic [HW*LW-1:0]  in_meta_match_len;
    logic [HW-1:0]     in_meta_match_can_ext;
    logic [HW*8-1:0]   in_data;
    logic              in_delim;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_hit;
    logic [AW-1:0]     out_addr;
    logic [AW-1:0]     out_history_addr;
    logic [LW-1:0]     out_meta_match_len;
    logic              out_meta_match_can_ext;
    logic [7:0]        out_data;
    logic              out_last;
    logic              out_delim;
`ifdef HASH_UNPACK_LEN_FILTER_EN
    logic [LW-1:0]     cfg_min_match_len = '0;
`endif

    hash_window_unpacker #(
        .HASH_ISSUE_WIDTH     (HW),
        .ADDR_WIDTH           (AW),
        .META_MATCH_LEN_WIDTH (LW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_head_addr           (in_head_addr),
        .in_history_valid       (in_history_valid),
        .in_history_addr        (in_history_addr),
        .in_meta_match_len      (in_meta_match_len),
        .in_meta_match_can_ext  (in_meta_match_can_ext),
        .in_data                (in_data),
        .in_delim               (in_delim),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_hit                (out_hit),
        .out_addr               (out_addr),
        .out_history_addr       (out_history_addr),
        .out_meta_match_len     (out_meta_match_len),
        .out_meta_match_can_ext (out_meta_match_can_ext),
        .out_data               (out_data),
        .out_last               (out_last),
        .out_delim              (out_delim)
`ifdef HASH_UNPACK_LEN_FILTER_EN
        ,
        .cfg_min_match_len      (cfg_min_match_len)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_mode = 0;

    logic [BW-1:0] exp_q[$];
    int            log_cyc[$];
    logic [AW-1:0] log_addr[$];
    int            acc_cyc[$];
    logic          hold_v = 1'b0;
    logic [BW-1:0] hold_p;
    logic [BW-1:0] exp_b;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] out_beat();
        return {out_hit, out_addr, out_history_addr, out_meta_match_len,
                out_meta_match_can_ext, out_data, out_last, out_delim};
    endfunction

    function automatic bit lane_kept(input int i);
        bit k = in_history_valid[i];
`ifdef HASH_UNPACK_LEN_FILTER_EN
        if (in_meta_match_len[i*LW +: LW] < cfg_min_match_len && !in_meta_match_can_ext[i]) k = 0;
`endif
        return k;
    endfunction

    // Reference: one beat per kept lane in ascending order; the last carries last/delim.
    task automatic model_window();
        int last_i = -1;
        for (int i = 0; i < HW; i++) if (lane_kept(i)) last_i = i;
        for (int i = 0; i < HW; i++) begin
            if (lane_kept(i))
                exp_q.push_back({1'b1, in_head_addr + AW'(i), in_history_addr[i*AW +: AW],
                                 in_meta_match_len[i*LW +: LW], in_meta_match_can_ext[i],
                                 in_data[i*8 +: 8], 1'(i == last_i), 1'((i == last_i) && in_delim)});
        end
        if (last_i < 0 && in_delim)
            exp_q.push_back({1'b0, in_head_addr, AW'(0), LW'(0), 1'b0, 8'h00, 1'b1, 1'b1});
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_payload", 64'(out_beat()), 64'(hold_p));
            end
            hold_v = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(out_valid), 64'd0);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("beat", 64'(out_beat()), 64'(exp_b));
                end
                log_cyc.push_back(cyc);
                log_addr.push_back(out_addr);
            end else if (out_valid) begin
                hold_v = 1'b1;
                hold_p = out_beat();
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                model_window();
            end
        end
    end

    task automatic set_window(input logic [AW-1:0] head, input logic [HW-1:0] hv, input logic dl);
        in_head_addr     = head;
        in_history_valid = hv;
        in_delim         = dl;
        for (int i = 0; i < HW; i++) begin
            in_history_addr[i*AW +: AW]   = AW'($urandom);
            in_meta_match_len[i*LW +: LW] = LW'($urandom);
            in_meta_match_can_ext[i]      = 1'($urandom);
            in_data[i*8 +: 8]             = 8'($urandom);
        end
    endtask

    task automatic send(output int waits);
        bit accepted = 0;
        waits = 0;
        in_valid = 1'b1;
        while (!accepted && waits < 200) begin
            @(negedge clk);
            if (in_ready) accepted = 1;
            @(posedge clk);
            #1;
            waits++;
        end
        in_valid = 1'b0;
        check("accept", 64'(accepted), 64'd1);
    endtask

    task automatic drain_all();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int n0;
        set_window('0, '0, 1'b0);
        tick(2);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        rst = 1'b0;
        tick(1);

        n0 = log_cyc.size();
        set_window(16'd100, 8'b1010_0100, 1'b0);
        send(w);
        drain_all();
        check("t040_count", 64'(log_cyc.size() - n0), 64'd3);
        if (log_cyc.size() - n0 == 3) begin
            check("t040_addr0", 64'(log_addr[n0]), 64'd102);
            check("t040_addr1", 64'(log_addr[n0+1]), 64'd105);
            check("t040_addr2", 64'(log_addr[n0+2]), 64'd107);
            check("t040_consec", 64'(log_cyc[n0+2] - log_cyc[n0]), 64'd2);
            check("t040_latency", 64'(log_cyc[n0] - acc_cyc[acc_cyc.size()-1]), 64'd1);
        end

        n0 = log_cyc.size();
        set_window(16'd200, 8'h00, 1'b0);
        send(w);
        check("t041_one_cycle", 64'(w), 64'd1);
        tick(3);
        check("t041_no_beat", 64'(log_cyc.size() - n0), 64'd0);
        check("t041_idle", 64'(out_valid), 64'd0);
        set_window(16'd64, 8'h00, 1'b1);
        send(w);
        drain_all();
        check("t041_delim_count", 64'(log_cyc.size() - n0), 64'd1);
        if (log_cyc.size() > n0) check("t041_delim_addr", 64'(log_addr[n0]), 64'd64);

        n0 = log_cyc.size();
        set_window(16'd10, 8'h81, 1'b0);
        send(w);
        set_window(16'd30, 8'h03, 1'b0);
        send(w);
        drain_all();
        check("t042_count", 64'(log_cyc.size() - n0), 64'd4);
        if (log_cyc.size() - n0 == 4) begin
            check("t042_consec", 64'(log_cyc[n0+3] - log_cyc[n0]), 64'd3);
            check("t042_b2b_accept", 64'(acc_cyc[acc_cyc.size()-1]), 64'(log_cyc[n0+1]));
        end

        n0 = log_cyc.size();
        set_window(16'hFFFE, 8'h08, 1'b0);
        send(w);
        drain_all();
        if (log_cyc.size() > n0) check("t043_wrap", 64'(log_addr[n0]), 64'd1);
        else check("t043_count", 64'(log_cyc.size() - n0), 64'd1);

        n0 = log_cyc.size();
        set_window(16'd300, 8'hFF, 1'b0);
        send(w);
        tick(2);
        out_mode = 2;
        tick(5);
        out_mode = 0;
        drain_all();
        check("t044_count", 64'(log_cyc.size() - n0), 64'd8);
        if (log_cyc.size() - n0 == 8)
            check("t044_stalled", 64'(log_cyc[n0+2] - log_cyc[n0+1] >= 5), 64'd1);

        set_window(16'd400, 8'hF0, 1'b0);
        send(w);
        tick(1);
        rst = 1'b1;
        #1;
        check("t044_rst_valid", 64'(out_valid), 64'd0);
        check("t044_rst_hit", 64'(out_hit), 64'd0);
        check("t044_rst_addr", 64'(out_addr), 64'd0);
        check("t044_rst_ready", 64'(in_ready), 64'd1);
        tick(1);
        rst = 1'b0;
        n0 = log_cyc.size();
        set_window(16'd500, 8'h11, 1'b1);
        send(w);
        drain_all();
        check("t044_restart_count", 64'(log_cyc.size() - n0), 64'd2);
        if (log_cyc.size() - n0 == 2) begin
            check("t044_restart_a0", 64'(log_addr[n0]), 64'd500);
            check("t044_restart_a1", 64'(log_addr[n0+1]), 64'd504);
        end

`ifdef HASH_UNPACK_LEN_FILTER_EN
        cfg_min_match_len = LW'(4);
        n0 = log_cyc.size();
        set_window(16'd600, 8'h07, 1'b0);
        in_meta_match_len[0*LW +: LW] = LW'(2); in_meta_match_can_ext[0] = 1'b0;
        in_meta_match_len[1*LW +: LW] = LW'(5); in_meta_match_can_ext[1] = 1'b0;
        in_meta_match_len[2*LW +: LW] = LW'(3); in_meta_match_can_ext[2] = 1'b1;
        send(w);
        drain_all();
        check("t045_count", 64'(log_cyc.size() - n0), 64'd2);
        if (log_cyc.size() - n0 == 2) begin
            check("t045_a0", 64'(log_addr[n0]), 64'd601);
            check("t045_a1", 64'(log_addr[n0+1]), 64'd602);
        end
`endif

        out_mode = 1;
        for (int k = 0; k < 40; k++) begin
            set_window(AW'($urandom),
                       ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom),
                       1'($urandom_range(0, 3) == 0));
            send(w);
        end
        drain_all();
        out_mode = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/hash_window_unpacker.md
HASH_WINDOW_UNPACKER -- requirements
Module: hash_window_unpacker

Interface
REQ-001 SHALL have parameter HASH_ISSUE_WIDTH, default `HASH_ISSUE_WIDTH from parameters.vh, meaning positions per window (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default `ADDR_WIDTH, meaning byte-address width.
REQ-003 SHALL have parameter META_MATCH_LEN_WIDTH, default `META_MATCH_LEN_WIDTH, meaning meta match length width.
REQ-004 Ports, in order: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 in_valid in 1; in_ready out 1; in_head_addr in ADDR_WIDTH; in_history_valid in HASH_ISSUE_WIDTH; in_history_addr in HASH_ISSUE_WIDTH*ADDR_WIDTH; in_meta_match_len in HASH_ISSUE_WIDTH*META_MATCH_LEN_WIDTH; in_meta_match_can_ext in HASH_ISSUE_WIDTH; in_data in HASH_ISSUE_WIDTH*8; in_delim in 1. These form the window stream produced by post_hash_pe_scheduler.
REQ-006 out_valid out 1; out_ready in 1; out_hit out 1 (1 = candidate beat, 0 = delim marker); out_addr out ADDR_WIDTH; out_history_addr out ADDR_WIDTH; out_meta_match_len out META_MATCH_LEN_WIDTH; out_meta_match_can_ext out 1; out_data out 8; out_last out 1; out_delim out 1.
REQ-007 cfg_min_match_len in META_MATCH_LEN_WIDTH, present only with HASH_UNPACK_LEN_FILTER_EN.

Function
REQ-010 Transfer on a port SHALL occur when valid and ready are both high on a rising clk edge; out_valid, once high, SHALL NOT drop and its payload SHALL NOT change until transfer.
REQ-011 State SHALL be IDLE or DRAIN, plus window register and pending mask (HASH_ISSUE_WIDTH bits).
REQ-012 in_ready SHALL be 1 in IDLE, and 1 in DRAIN only when out_valid & out_ready & out_last (back-to-back accept).
REQ-013 On input transfer, pending mask SHALL load in_history_valid (filtered per REQ-030); if mask nonzero or in_delim=1, state SHALL go to DRAIN, else stay/return to IDLE with no output beat.
REQ-014 out_valid SHALL equal (state==DRAIN); first beat valid the cycle after input transfer (latency 1).
REQ-015 Beat index i SHALL be the lowest set bit of pending mask; out_addr = head_addr + i (mod 2^ADDR_WIDTH wrap); out_history_addr, out_meta_match_len, out_meta_match_can_ext, out_data SHALL be lane i fields; out_hit=1.
REQ-016 On output transfer, bit i SHALL clear; out_last SHALL be 1 when exactly one pending bit remains.
REQ-017 Empty-mask delim window: exactly one beat with out_hit=0, out_last=1, out_delim=1, out_addr=head_addr, other payload zero.
REQ-018 out_delim SHALL be 1 only on the last beat of a window with in_delim=1.
REQ-019 On output transfer with out_last=1: if input transfer same cycle, reload per REQ-013; else go IDLE.
REQ-020 Throughput SHALL be one beat per cycle; window with k>0 hits occupies exactly k output cycles.

Reset
REQ-025 rst high SHALL immediately force IDLE, clear pending mask and window register, out_valid=0, in_ready=1, all payload outputs 0; mid-window data SHALL be discarded.

Configuration
REQ-030 Macro HASH_UNPACK_LEN_FILTER_EN: when defined, lanes with meta_match_len < cfg_min_match_len and can_ext=0 SHALL be cleared from the loaded mask; when undefined, port cfg_min_match_len SHALL be absent and no filtering applied.

Structure
REQ-035 Widths SHALL come from parameters.vh; beat-type encoding and FSM state constants SHALL reside in a shared package/header post_hash_pkg.
REQ-036 One sub-module SHALL exist: lowest_one_encoder (mask -> index, onehot, single-bit flag).

Verification (bench HASH_ISSUE_WIDTH=8)
REQ-040 head=100, history_valid=8'b1010_0100, delim=0, out_ready=1 -> beats out_addr 102,105,107 on 3 consecutive cycles, out_last only on 107.
REQ-041 history_valid=0, delim=0 -> accepted in one cycle, no beat; history_valid=0, delim=1, head=64 -> single beat out_hit=0, out_addr=64, out_last=1, out_delim=1.
REQ-042 Two windows 0x81 then 0x03 back-to-back with out_ready=1 -> 4 beats on 4 consecutive cycles, in_ready=1 on 2nd beat cycle.
REQ-043 head=2^ADDR_WIDTH-2, mask 0x08 -> out_addr=1 (wrap).
REQ-044 out_ready held 0 for 5 cycles mid-window -> payload stable, no beat lost or duplicated; rst pulse during DRAIN -> out_valid=0 same cycle, next window restarts cleanly.
REQ-045 With HASH_UNPACK_LEN_FILTER_EN, cfg_min_match_len=4, lanes len {2,5,3(can_ext=1)} -> only len 5 and len 3 lanes emitted.
